// File: rtl/cic_dec4.sv
// Four-lane CIC decimator: per-lane parallel integrators, one shared comb engine
// serialising lanes 0..3 onto a valid/ready stream. Define CIC_OUT_SAT_EN to saturate output.
module cic_dec4_integ #(
  parameter int STAGES = 4,
  parameter int IW     = 18,
  parameter int AW     = 50
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] x_i,
  output logic [AW-1:0] acc_o
);
  logic [STAGES-1:0][AW-1:0] acc_q;

  // Wrap-around accumulation is intentional; the comb differences cancel it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q[0] <= acc_q[0] + {{(AW-IW){x_i[IW-1]}}, x_i};
      for (int k = 1; k < STAGES; k++) acc_q[k] <= acc_q[k] + acc_q[k-1];
    end
  end

  assign acc_o = acc_q[STAGES-1];
endmodule

module cic_dec4 #(
  parameter int STAGES = 4,
  parameter int IW     = 18,
  parameter int OW     = 18,
  parameter int AW     = 50
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] in0_i,
  input  logic [IW-1:0] in0_q,
  input  logic [IW-1:0] in1_i,
  input  logic [IW-1:0] in1_q,
  input  logic [7:0]    rate,
  input  logic [5:0]    shift,
  output logic [OW-1:0] out_data,
  output logic [1:0]    out_lane,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overrun,
  input  logic          clr_ovr
);
  localparam int NUM_LANES = 4;
  localparam int RW        = AW + 1;
  localparam logic signed [RW-1:0] MAXV = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMB, HOLD} st_e;

  st_e                                    st_q, st_d;
  logic [1:0]                             lane_q, lane_d;
  logic [7:0]                             cnt_q, cnt_d, rate_q, rate_d;
  logic                                   rvld_q, rvld_d;
  logic [NUM_LANES-1:0][AW-1:0]           snap_q, snap_d;
  logic [NUM_LANES-1:0][STAGES-1:0][AW-1:0] dly_q, dly_d;
  logic [OW-1:0]                          od_q, od_d;
  logic [1:0]                             ol_q, ol_d;
  logic                                   ov_q, ov_d, ovr_q, ovr_d;

  logic [NUM_LANES-1:0][IW-1:0] x_lane;
  logic [NUM_LANES-1:0][AW-1:0] integ_out;
  logic [7:0]                   rate_cl, rate_eff;
  logic                         tick, hs, free;
  logic [STAGES:0][AW-1:0]      stg;
  logic signed [RW-1:0]         rbit, rnd, shv;
  logic [OW-1:0]                res;

  assign x_lane = {in1_q, in1_i, in0_q, in0_i};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cic_dec4_integ #(.STAGES(STAGES), .IW(IW), .AW(AW)) u_integ (
      .clk   (clk),
      .rst   (rst),
      .x_i   (x_lane[g]),
      .acc_o (integ_out[g])
    );
  end

  // Until the first period is loaded, the live rate input defines the period.
  assign rate_cl  = (rate < 8'd8) ? 8'd8 : rate;
  assign rate_eff = rvld_q ? rate_q : rate_cl;
  assign tick     = (cnt_q == rate_eff - 8'd1);
  assign hs       = ov_q & out_ready;
  assign free     = (st_q == IDLE) || (st_q == HOLD && hs && lane_q == 2'd3);

  always_comb begin
    stg[0] = snap_q[lane_q];
    for (int k = 0; k < STAGES; k++) stg[k+1] = stg[k] - dly_q[lane_q][k];
    rbit = (shift != 6'd0) ? (RW'(1) << (shift - 6'd1)) : '0;
    rnd  = $signed({stg[STAGES][AW-1], stg[STAGES]}) + rbit;
    shv  = rnd >>> shift;
`ifdef CIC_OUT_SAT_EN
    if (shv > MAXV)      res = OW'(MAXV);
    else if (shv < MINV) res = OW'(MINV);
    else                 res = OW'(shv);
`else
    res = OW'(shv);
`endif
  end

  always_comb begin
    st_d   = st_q;
    lane_d = lane_q;
    snap_d = snap_q;
    dly_d  = dly_q;
    od_d   = od_q;
    ol_d   = ol_q;
    ov_d   = ov_q;
    ovr_d  = ovr_q;
    cnt_d  = tick ? 8'd0 : cnt_q + 8'd1;
    rate_d = (tick || !rvld_q) ? rate_cl : rate_q;
    rvld_d = 1'b1;

    if (tick && free) snap_d = integ_out;
    if (tick && !free) ovr_d = 1'b1;
    else if (clr_ovr)  ovr_d = 1'b0;

    case (st_q)
      IDLE: if (tick) begin
        st_d   = COMB;
        lane_d = 2'd0;
      end
      COMB: begin
        dly_d[lane_q] = stg[STAGES-1:0];
        od_d = res;
        ol_d = lane_q;
        ov_d = 1'b1;
        st_d = HOLD;
      end
      HOLD: if (hs) begin
        ov_d = 1'b0;
        if (lane_q != 2'd3) begin
          st_d   = COMB;
          lane_d = lane_q + 2'd1;
        end else if (tick) begin
          st_d   = COMB;
          lane_d = 2'd0;
        end else begin
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      lane_q <= '0;
      cnt_q  <= '0;
      rate_q <= '0;
      rvld_q <= 1'b0;
      snap_q <= '0;
      dly_q  <= '0;
      od_q   <= '0;
      ol_q   <= '0;
      ov_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
      rvld_q <= rvld_d;
      snap_q <= snap_d;
      dly_q  <= dly_d;
      od_q   <= od_d;
      ol_q   <= ol_d;
      ov_q   <= ov_d;
      ovr_q  <= ovr_d;
    end
  end

  assign out_data  = od_q;
  assign out_lane  = ol_q;
  assign out_valid = ov_q;
  assign overrun   = ovr_q;
endmodule

// File: tb/tb_cic_dec4.sv
// Randomised bench for cic_dec4: cumulative-sum integrators plus a 4th-order finite
// difference over accepted snapshots, with a set-level accept/drop model.
module tb_cic_dec4;
  localparam int STAGES = 4, IW = 18, OW = 18, AW = 50;

  logic clk = 1'b0;
  logic rst;
  logic signed [IW-1:0] x [4];
  logic [7:0] rate;
  logic [5:0] shift;
  logic [OW-1:0] out_data;
  logic [1:0] out_lane;
  logic out_valid, out_ready, overrun, clr_ovr;

  cic_dec4 #(.STAGES(STAGES), .IW(IW), .OW(OW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in0_i(x[0]), .in0_q(x[1]), .in1_i(x[2]), .in1_q(x[3]),
    .rate(rate), .shift(shift),
    .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  typedef struct { int lane; longint data; int cyc; bit lat; } exp_t;
  exp_t expq[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [AW-1:0] m_acc [4][STAGES];
  logic [AW-1:0] m_hist [4][5];
  int m_cnt, m_len, m_rem;
  bit m_have, m_ovr;
  bit lat_phase, rnd_in, first_after;
  int n_hs [4];
  int last_hs [4];
  longint last_d [4];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clampr(input logic [7:0] r);
    return (r < 8'd8) ? 8 : int'(r);
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < STAGES; k++) m_acc[l][k] = '0;
      for (int j = 0; j < 5; j++) m_hist[l][j] = '0;
    end
    m_cnt = 0; m_len = 8; m_rem = 0; m_have = 0; m_ovr = 0;
    expq.delete();
  endtask

  // One clock of reference behaviour, evaluated on the pre-edge values.
  task automatic model_edge();
    bit hs, tick, acc;
    exp_t e;
    logic [AW-1:0] y;
    longint v;
    int sh;
    hs = out_valid && out_ready;
    acc = 0;
    if (hs) begin
      if (first_after) begin
        chk("rst_first_lane", out_lane, 0);
        first_after = 0;
      end
      chk("hs_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("lane", out_lane, e.lane);
        chk("data", $signed(out_data), e.data);
        if (e.lat) chk("latency", cyc, e.cyc);
        last_d[e.lane] = $signed(out_data);
        last_hs[e.lane] = cyc;
        n_hs[e.lane]++;
        m_rem--;
      end
    end
    if (!m_have) begin
      m_len = clampr(rate);
      m_have = 1;
    end
    tick = (m_cnt == m_len - 1);
    if (tick) begin
      acc = (m_rem == 0);
      if (acc) begin
        for (int l = 0; l < 4; l++) begin
          for (int j = 4; j > 0; j--) m_hist[l][j] = m_hist[l][j-1];
          m_hist[l][0] = m_acc[l][STAGES-1];
          y = m_hist[l][0] - 4*m_hist[l][1] + 6*m_hist[l][2] - 4*m_hist[l][3] + m_hist[l][4];
          v = longint'($signed(y));
          sh = int'(shift);
          if (sh > 0) v = v + (longint'(1) << (sh - 1));
          v = v >>> sh;
`ifdef CIC_OUT_SAT_EN
          if (v > 131071) v = 131071;
          if (v < -131072) v = -131072;
`endif
          v = longint'($signed(v[OW-1:0]));
          e.lane = l; e.data = v; e.cyc = cyc + 2 + 2*l; e.lat = lat_phase;
          expq.push_back(e);
        end
        m_rem = 4;
      end
      m_cnt = 0;
      m_len = clampr(rate);
    end else begin
      m_cnt++;
    end
    if (tick && !acc) m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
    for (int l = 0; l < 4; l++) begin
      for (int k = STAGES-1; k > 0; k--) m_acc[l][k] = m_acc[l][k] + m_acc[l][k-1];
      m_acc[l][0] = m_acc[l][0] + {{(AW-IW){x[l][IW-1]}}, x[l]};
    end
  endtask

  task automatic step();
    if (rnd_in) for (int l = 0; l < 4; l++) x[l] = IW'($urandom);
    if (!rst) model_reset();
    else model_edge();
    @(posedge clk); #1;
    cyc++;
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_hs(input int lane, input int maxc, input string tag);
    int n0;
    n0 = n_hs[lane];
    for (int i = 0; i < maxc && n_hs[lane] == n0; i++) step();
    chk(tag, n_hs[lane] != n0, 1);
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    for (int i = 0; i < maxc && !(out_valid && out_lane == 2'd0); i++) step();
    chk(tag, out_valid && out_lane == 2'd0, 1);
  endtask

  task automatic set_x(input int a, input int b, input int c, input int d);
    x[0] = IW'(a); x[1] = IW'(b); x[2] = IW'(c); x[3] = IW'(d);
  endtask

  initial begin
    int c0, c1, c2;
    rst = 1'b0; rate = 8'd16; shift = 6'd16; out_ready = 1'b1; clr_ovr = 1'b0;
    rnd_in = 0; lat_phase = 1; first_after = 0;
    for (int l = 0; l < 4; l++) begin n_hs[l] = 0; last_hs[l] = 0; last_d[l] = 0; end
    set_x(0, 0, 0, 0);
    model_reset();
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_lane", out_lane, 0);
    chk("rst_ovr", overrun, 0);
    run(2);

    // DC gain
    set_x(1000, 1000, 1000, 1000);
    rst = 1'b1;
    run(10*16);
    for (int l = 0; l < 4; l++) chk("dc_gain", last_d[l], 1000);

    // sign and lane separation
    set_x(500, -500, 1, -131072);
    run(8*16);
    chk("sep_l0", last_d[0], 500);
    chk("sep_l1", last_d[1], -500);
    chk("sep_l2", last_d[2], 1);
    chk("sep_l3", last_d[3], -131072);

    // output saturation / wrap, gain x4
    wait_hs(3, 40, "to_sat");
    shift = 6'd14;
    set_x(131071, 131071, 131071, 131071);
    run(8*16);
    for (int l = 0; l < 4; l++) begin
`ifdef CIC_OUT_SAT_EN
      chk("sat", last_d[l], 131071);
`else
      chk("wrap", last_d[l], -4);
`endif
    end

    // rate change mid-period
    wait_hs(3, 40, "to_rc");
    shift = 6'd20;
    set_x(1000, 1000, 1000, 1000);
    wait_hs(0, 40, "to_rc0");
    c0 = last_hs[0];
    run(4);
    rate = 8'd32;
    wait_hs(0, 60, "to_rc1");
    c1 = last_hs[0];
    wait_hs(0, 60, "to_rc2");
    c2 = last_hs[0];
    chk("period_old", c1 - c0, 16);
    chk("period_new", c2 - c1, 32);
    run(7*32);
    for (int l = 0; l < 4; l++) chk("rc_dc", last_d[l], 1000);

    // back-pressure overrun at the minimum rate
    wait_hs(3, 80, "to_bp");
    shift = 6'd12; rate = 8'd8; lat_phase = 0; rnd_in = 1;
    wait_valid(80, "to_bp_valid");
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_lane", out_lane, 0);
      if (expq.size() > 0) chk("hold_data", $signed(out_data), expq[0].data);
    end
    chk("ovr_set", overrun, 1);
    out_ready = 1'b1;
    run(40);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // randomised traffic: rates (incl. <8), back-pressure, clears
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) rate = 8'($urandom_range(2, 30));
      out_ready = ($urandom_range(0, 9) < 7);
      clr_ovr = ($urandom_range(0, 19) == 0);
      step();
    end
    clr_ovr = 1'b0;

    // asynchronous reset while holding an output
    out_ready = 1'b0;
    for (int i = 0; i < 100 && !out_valid; i++) step();
    chk("pre_rst_valid", out_valid, 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_lane", out_lane, 0);
    chk("arst_ovr", overrun, 0);
    run(3);
    rate = 8'd16; out_ready = 1'b1; lat_phase = 1;
    rst = 1'b1;
    first_after = 1;
    c0 = n_hs[0];
    run(100);
    chk("post_rst_sets", n_hs[0] > c0, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/cic_dec4.md
Name: cic_dec4

Overview:
- Four-lane CIC decimator directly downstream of the dual-receiver NCO mixer.
- Consumes the four 18-bit mixer products (rx0 I/Q, rx1 I/Q) every clk and integrates them in parallel.
- On each decimation tick, a single shared comb engine processes the four lanes sequentially.
- Results leave as a lane-tagged serial stream with a valid/ready handshake, toward the FIR/packetiser stage.

Parameters:
- STAGES, 4, number of integrator and comb stages (differential delay 1).
- IW, 18, input sample width (signed).
- OW, 18, output sample width (signed).
- AW, 50, accumulator width; must be ≥ IW + STAGES*8.

Ports:
- clk  in  1  system clock; mixer outputs are valid every cycle.
- rst  in  1  asynchronous, active-low reset.
- in0_i  in  IW  rx0 I sample, lane 0.
- in0_q  in  IW  rx0 Q sample, lane 1.
- in1_i  in  IW  rx1 I sample, lane 2.
- in1_q  in  IW  rx1 Q sample, lane 3.
- rate  in  8  decimation ratio R; legal range 8..255.
- shift  in  6  output right-shift (gain normalisation), 0..AW-OW.
- out_data  out  OW  decimated sample.
- out_lane  out  2  lane index of out_data.
- out_valid  out  1  out_data/out_lane valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- overrun  out  1  sticky flag: a decimated sample set was dropped.
- clr_ovr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0, asynchronous): integrators, comb delays, snapshot, and decimation counter = 0; FSM = IDLE; out_data=0, out_lane=0, out_valid=0, overrun=0.
- Integrators: each lane has STAGES cascaded AW-bit accumulators, updated every clk. Input is sign-extended to AW. Wrap-around arithmetic is intended and required; no saturation inside the integrators.
- Decimation counter:
  - Counts 0..rate-1, then wraps.
  - tick = 1 in the cycle the counter equals rate-1.
  - rate is sampled at the wrap, so a change takes effect on the next period.
  - rate < 8 is treated as 8.
- Snapshot: on tick, the last-stage integrator values of all 4 lanes are latched. They are visible to the FSM in cycle t+1.
- FSM states:
  - IDLE: waits for tick.
  - COMB: one cycle per lane. Runs the STAGES-deep comb chain for the current lane combinationally and updates that lane's comb delay registers. Then round-half-up: add bit (shift-1) when shift>0, arithmetic right shift by shift, saturate to OW bits. Loads out_data and out_lane, sets out_valid=1, goes to HOLD.
  - HOLD: keeps out_valid=1 and out_data/out_lane stable until out_ready=1. On the handshake, out_valid drops in the next cycle. If lane<3, go to COMB with lane+1; otherwise go to IDLE.
- Latency with out_ready tied high:
  - Lane 0 out_valid rises at t+2 after the tick cycle t.
  - Lanes 1, 2, 3 follow at t+4, t+6, t+8.
  - A full set completes in 8 cycles, which is ≤ R.
- Simultaneous events:
  - tick while the FSM is in IDLE: normal start.
  - tick while the FSM is not in IDLE: the new snapshot is discarded, comb delays are not updated for it, and overrun is set. The in-flight set completes untouched.
  - tick and the lane-3 handshake in the same cycle: accepted as a normal start; the FSM goes directly to COMB lane 0.
  - clr_ovr and an overrun event in the same cycle: set wins.
- Reset mid-stream: all state clears immediately; the first post-reset output set is a filter transient.
- Integrators never stall. Back-pressure only causes dropped sets, never corrupt integrator state.

Optional Feature:
- Macro: CIC_OUT_SAT_EN.
- Defined: the final shifted value is saturated to [-2^(OW-1), 2^(OW-1)-1].
- Undefined: the final value is truncated to its low OW bits (wraps). This saves logic when shift is chosen for guaranteed headroom.

Test Plan:
- DC gain: all lanes = +1000, rate=16, shift=16, out_ready=1. From the 5th set onward, every lane outputs exactly 1000, lanes ordered 0,1,2,3.
- Sign/lane separation: in0_i=+500, in0_q=-500, in1_i=+1, in1_q=-131072, rate=16, shift=16. Steady state gives 500, -500, 1, -131072 on lanes 0..3.
- Back-pressure overrun: rate=8, out_ready held low for 20 cycles after the first tick. Lane 0 is held stable, overrun=1, the next set is dropped, and clr_ovr returns overrun to 0.
- Saturation: input +131071 on all lanes, rate=16, shift=14 (gain ×4). With CIC_OUT_SAT_EN, output = 131071. Without it, output = the wrapped low 18 bits.
- Async reset mid-HOLD: assert rst low while out_valid=1. Outputs go to 0 immediately, without a clock edge. After release, the first tick restarts at lane 0.
- Rate change: switch rate 16→32 mid-period. The current period stays 16 cycles and the next is 32. The DC output with shift=20 settles to 1000.
